// File: rtl/ext_port_bridge.sv
// Host-side bridge for the CPU external port: a TX FIFO (CPU OUT -> host) and an RX FIFO (host -> CPU IN).
// Optional EXT_PORT_STALL_EN adds cpu_stall back-pressure so that a full TX FIFO never drops a byte.
module ext_port_bridge #(
   parameter int          DEPTH     = 4,
   parameter int          AW        = 2,
   parameter logic [7:0]  EMPTY_VAL = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    cpu_ext_out,
   input  logic          cpu_out_stb,
   output logic [7:0]    cpu_ext_in,
   input  logic          cpu_in_stb,
   output logic          cpu_in_empty,
   output logic [7:0]    host_rx_data,
   output logic          host_rx_valid,
   input  logic          host_rx_ready,
   input  logic [7:0]    host_tx_data,
   input  logic          host_tx_valid,
   output logic          host_tx_ready,
   output logic [AW:0]   out_level,
   output logic          ovf_sticky
`ifdef EXT_PORT_STALL_EN
   ,
   output logic          cpu_stall
`endif
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  omem [DEPTH];
   logic [7:0]  imem [DEPTH];

   logic [AW:0] owp_q, owp_d, orp_q, orp_d;
   logic [AW:0] iwp_q, iwp_d, irp_q, irp_d;
   logic        ovf_q, ovf_d;
   logic        rdy_en_q;

   logic        out_full, out_empty, in_full, in_empty;
   logic        o_push, o_pop, i_push, i_pop;

   assign out_empty = (owp_q == orp_q);
   assign out_full  = (owp_q[AW-1:0] == orp_q[AW-1:0]) && (owp_q[AW] != orp_q[AW]);
   assign in_empty  = (iwp_q == irp_q);
   assign in_full   = (iwp_q[AW-1:0] == irp_q[AW-1:0]) && (iwp_q[AW] != irp_q[AW]);

   // Outputs the host sees are functions of registered state only.
   assign host_rx_valid = !out_empty;
   assign host_rx_data  = omem[orp_q[AW-1:0]];
   assign host_tx_ready = rdy_en_q && !in_full;
   assign cpu_in_empty  = in_empty;
   assign cpu_ext_in    = in_empty ? EMPTY_VAL : imem[irp_q[AW-1:0]];
   assign out_level     = owp_q - orp_q;
   assign ovf_sticky    = ovf_q;

   assign o_pop  = host_rx_valid && host_rx_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign o_push = cpu_out_stb && (!out_full || o_pop);
   assign i_push = host_tx_valid && host_tx_ready;
   assign i_pop  = cpu_in_stb && !in_empty;

`ifdef EXT_PORT_STALL_EN
   assign cpu_stall = out_full && !o_pop;
`endif

   always_comb begin
      owp_d = owp_q;
      orp_d = orp_q;
      iwp_d = iwp_q;
      irp_d = irp_q;
      ovf_d = ovf_q;
      if (o_push) owp_d = owp_q + PTR_ONE;
      if (o_pop)  orp_d = orp_q + PTR_ONE;
      if (i_push) iwp_d = iwp_q + PTR_ONE;
      if (i_pop)  irp_d = irp_q + PTR_ONE;
`ifndef EXT_PORT_STALL_EN
      if (cpu_out_stb && out_full && !o_pop) ovf_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owp_q    <= '0;
         orp_q    <= '0;
         iwp_q    <= '0;
         irp_q    <= '0;
         ovf_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         owp_q    <= owp_d;
         orp_q    <= orp_d;
         iwp_q    <= iwp_d;
         irp_q    <= irp_d;
         ovf_q    <= ovf_d;
         rdy_en_q <= 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (o_push) omem[owp_q[AW-1:0]] <= cpu_ext_out;
      if (i_push) imem[iwp_q[AW-1:0]] <= host_tx_data;
   end

endmodule
